// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine between an
// encrypt and a decrypt requester, with range check and engine timeout.
module modexp_arbiter #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keys_ready,
  input  logic [31:0] n_key,
  input  logic [31:0] e_key,
  input  logic [31:0] d_key,
  input  logic        enc_req,
  input  logic [31:0] enc_data,
  output logic        enc_ack,
  input  logic        dec_req,
  input  logic [31:0] dec_data,
  output logic        dec_ack,
  output logic        eng_start,
  output logic [31:0] eng_base,
  output logic [31:0] eng_exp,
  output logic [31:0] eng_mod,
  input  logic        eng_done,
  input  logic [31:0] eng_result,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_dec,
  output logic        res_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_owner;
  logic             r_last_dec;
  logic             r_enc_ack;
  logic             r_dec_ack;
  logic             r_eng_start;
  logic [31:0]      r_eng_base;
  logic [31:0]      r_eng_exp;
  logic [31:0]      r_eng_mod;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic             r_res_dec;
  logic             r_res_err;

  logic             w_grant;
  logic             w_pick_dec;
  logic [31:0]      w_data;

  // On a tie the requester that did not win last time is served.
  assign w_grant    = keys_ready & (enc_req | dec_req);
  assign w_pick_dec = dec_req & (~enc_req | ~r_last_dec);
  assign w_data     = w_pick_dec ? dec_data : enc_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_owner     <= 1'b0;
      r_last_dec  <= 1'b1;
      r_enc_ack   <= 1'b0;
      r_dec_ack   <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_base  <= '0;
      r_eng_exp   <= '0;
      r_eng_mod   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_dec   <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_enc_ack   <= 1'b0;
      r_dec_ack   <= 1'b0;
      r_eng_start <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_pick_dec;
            r_enc_ack <= ~w_pick_dec;
            r_dec_ack <= w_pick_dec;
            if (w_data >= n_key) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_res_err   <= 1'b1;
              r_res_data  <= '0;
              r_res_dec   <= w_pick_dec;
            end else begin
              r_state     <= S_ISSUE;
              r_eng_start <= 1'b1;
              r_eng_base  <= w_data;
              r_eng_exp   <= w_pick_dec ? d_key : e_key;
              r_eng_mod   <= n_key;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_timer <= '0;
        end
        S_WAIT: begin
          // A done arriving on the last timeout cycle still counts as success.
          if (eng_done) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b0;
            r_res_data  <= eng_result;
            r_res_dec   <= r_owner;
          end else if (r_timer == TMR_LAST) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_data  <= '0;
            r_res_dec   <= r_owner;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_DONE: begin
          r_last_dec <= r_owner;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign enc_ack   = r_enc_ack;
  assign dec_ack   = r_dec_ack;
  assign eng_start = r_eng_start;
  assign eng_base  = r_eng_base;
  assign eng_exp   = r_eng_exp;
  assign eng_mod   = r_eng_mod;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_dec   = r_res_dec;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter: a default-timeout instance and a
// TIMEOUT_CYC=16 instance share stimulus; each test checks one of them.
module tb_modexp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        keys_ready = 1'b0;
  logic [31:0] n_key = '0, e_key = '0, d_key = '0;
  logic        enc_req = 1'b0, dec_req = 1'b0;
  logic [31:0] enc_data = '0, dec_data = '0;
  logic        eng_done = 1'b0;
  logic [31:0] eng_result = '0;

  logic        enc_ack, dec_ack, eng_start, res_valid, res_dec, res_err;
  logic [31:0] eng_base, eng_exp, eng_mod, res_data;
  logic        s_enc_ack, s_dec_ack, s_eng_start, s_res_valid, s_res_dec, s_res_err;
  logic [31:0] s_eng_base, s_eng_exp, s_eng_mod, s_res_data;

  int n_checks = 0;
  int n_pass   = 0;
  int eng_cnt  = 0;

  always #5 clk = ~clk;

  modexp_arbiter dut (
    .clk(clk), .rst(rst), .keys_ready(keys_ready),
    .n_key(n_key), .e_key(e_key), .d_key(d_key),
    .enc_req(enc_req), .enc_data(enc_data), .enc_ack(enc_ack),
    .dec_req(dec_req), .dec_data(dec_data), .dec_ack(dec_ack),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_done(eng_done), .eng_result(eng_result),
    .res_valid(res_valid), .res_data(res_data), .res_dec(res_dec), .res_err(res_err)
  );

  modexp_arbiter #(.TIMEOUT_CYC(16)) dut_s (
    .clk(clk), .rst(rst), .keys_ready(keys_ready),
    .n_key(n_key), .e_key(e_key), .d_key(d_key),
    .enc_req(enc_req), .enc_data(enc_data), .enc_ack(s_enc_ack),
    .dec_req(dec_req), .dec_data(dec_data), .dec_ack(s_dec_ack),
    .eng_start(s_eng_start), .eng_base(s_eng_base), .eng_exp(s_eng_exp), .eng_mod(s_eng_mod),
    .eng_done(eng_done), .eng_result(eng_result),
    .res_valid(s_res_valid), .res_data(s_res_data), .res_dec(s_res_dec), .res_err(s_res_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine replies lat cycles after the current sample point.
  task automatic run_engine(input int lat, input logic [31:0] result);
    repeat (lat - 1) tick();
    eng_done   = 1'b1;
    eng_result = result;
    tick();
    eng_done = 1'b0;
  endtask

  // Engine model answering each main-instance eng_start after 3 cycles.
  task automatic eng_step();
    eng_done = 1'b0;
    if (eng_start) eng_cnt = 3;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int    ngr;
    int    viol;
    logic  prev_ack;
    logic  seen;
    logic  gseq [4];

    // Reset state
    tick();
    tick();
    check("rst_ctrl", {26'd0, enc_ack, dec_ack, eng_start, res_valid, res_dec, res_err}, 32'd0);
    check("rst_data", eng_base | eng_exp | eng_mod | res_data, 32'd0);
    rst = 1'b0;

    // Encrypt 65 with n=3233 e=17, engine answers 2790 after 40 cycles
    n_key = 32'd3233; e_key = 32'd17; d_key = 32'd2753; keys_ready = 1'b1;
    enc_data = 32'd65; enc_req = 1'b1;
    tick();
    check("enc_ack", {31'd0, enc_ack}, 32'd1);
    check("enc_other_ack", {31'd0, dec_ack}, 32'd0);
    check("enc_start", {31'd0, eng_start}, 32'd1);
    check("enc_base", eng_base, 32'd65);
    check("enc_exp", eng_exp, 32'd17);
    check("enc_mod", eng_mod, 32'd3233);
    enc_req = 1'b0;
    n_key = 32'd999; e_key = 32'd3;
    tick();
    check("start_pulse", {31'd0, eng_start}, 32'd0);
    check("ack_pulse", {31'd0, enc_ack}, 32'd0);
    check("ops_held", eng_base ^ eng_exp ^ eng_mod, 32'd65 ^ 32'd17 ^ 32'd3233);
    n_key = 32'd3233; e_key = 32'd17;
    run_engine(39, 32'd2790);
    check("enc_res_valid", {31'd0, res_valid}, 32'd1);
    check("enc_res_data", res_data, 32'd2790);
    check("enc_res_dec", {31'd0, res_dec}, 32'd0);
    check("enc_res_err", {31'd0, res_err}, 32'd0);
    tick();
    check("res_pulse", {31'd0, res_valid}, 32'd0);

    // keys_ready gating
    keys_ready = 1'b0; enc_data = 32'd5; enc_req = 1'b1;
    seen = 1'b0;
    repeat (4) begin tick(); seen |= enc_ack | dec_ack; end
    check("no_keys_no_ack", {31'd0, seen}, 32'd0);
    keys_ready = 1'b1;
    tick();
    check("keys_ack", {31'd0, enc_ack}, 32'd1);
    enc_req = 1'b0;
    pulse_reset();

    // Round-robin with both requesters held from reset
    enc_data = 32'd10; dec_data = 32'd20; eng_result = 32'h1234;
    enc_req = 1'b1; dec_req = 1'b1;
    ngr = 0; viol = 0; prev_ack = 1'b0; eng_cnt = 0;
    for (int c = 0; c < 200 && ngr < 4; c++) begin
      tick();
      if (enc_ack && dec_ack) viol++;
      if ((enc_ack || dec_ack) && prev_ack) viol++;
      prev_ack = enc_ack | dec_ack;
      if (enc_ack || dec_ack) begin gseq[ngr] = dec_ack; ngr++; end
      eng_step();
    end
    enc_req = 1'b0; dec_req = 1'b0;
    for (int c = 0; c < 10; c++) begin tick(); eng_step(); end
    eng_done = 1'b0;
    check("rr_grants", ngr, 32'd4);
    check("rr_g0", {31'd0, gseq[0]}, 32'd0);
    check("rr_g1", {31'd0, gseq[1]}, 32'd1);
    check("rr_g2", {31'd0, gseq[2]}, 32'd0);
    check("rr_g3", {31'd0, gseq[3]}, 32'd1);
    check("rr_ack_width", viol, 32'd0);
    check("rr_last_res", res_data, 32'h1234);

    // Out-of-range decrypt is rejected without using the engine
    dec_data = 32'd3233; dec_req = 1'b1;
    tick();
    check("rej_ack", {31'd0, dec_ack}, 32'd1);
    check("rej_no_start", {31'd0, eng_start}, 32'd0);
    check("rej_valid", {31'd0, res_valid}, 32'd1);
    check("rej_err", {31'd0, res_err}, 32'd1);
    check("rej_data", res_data, 32'd0);
    check("rej_dec", {31'd0, res_dec}, 32'd1);
    dec_req = 1'b0;
    tick();
    check("rej_pulse", {31'd0, res_valid}, 32'd0);

    // Timeout on the 16-cycle instance
    pulse_reset();
    enc_data = 32'd7; enc_req = 1'b1;
    tick();
    check("to_ack", {30'd0, s_enc_ack, s_eng_start}, 32'd3);
    enc_req = 1'b0;
    seen = 1'b0;
    repeat (16) begin tick(); seen |= s_res_valid; end
    check("to_early", {31'd0, seen}, 32'd0);
    tick();
    check("to_valid", {31'd0, s_res_valid}, 32'd1);
    check("to_err", {31'd0, s_res_err}, 32'd1);
    check("to_data", s_res_data, 32'd0);
    eng_done = 1'b1; eng_result = 32'd99;
    seen = 1'b0;
    repeat (3) begin tick(); seen |= s_res_valid; end
    eng_done = 1'b0;
    check("late_done_ignored", {31'd0, seen}, 32'd0);
    dec_data = 32'd100; dec_req = 1'b1;
    tick();
    check("after_to_ack", {31'd0, s_dec_ack}, 32'd1);
    dec_req = 1'b0;
    run_engine(4, 32'd555);
    check("after_to_valid", {29'd0, s_res_valid, s_res_err, s_res_dec}, 32'b101);
    check("after_to_data", s_res_data, 32'd555);

    // Done on the final timeout cycle wins
    tick();
    enc_data = 32'd8; enc_req = 1'b1;
    tick();
    check("edge_ack", {31'd0, s_enc_ack}, 32'd1);
    enc_req = 1'b0;
    run_engine(17, 32'd4321);
    check("edge_valid", {30'd0, s_res_valid, s_res_err}, 32'b10);
    check("edge_data", s_res_data, 32'd4321);

    // Reset during WAIT aborts silently
    pulse_reset();
    dec_data = 32'd50; dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_ctrl", {26'd0, enc_ack, dec_ack, eng_start, res_valid, res_dec, res_err}, 32'd0);
    check("midrst_data", eng_base | eng_exp | eng_mod | res_data, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= res_valid | enc_ack | dec_ack | eng_start; end
    check("midrst_silent", {31'd0, seen}, 32'd0);
    dec_data = 32'd60; dec_req = 1'b1;
    tick();
    check("post_rst_ack", {30'd0, dec_ack, eng_start}, 32'd3);
    check("post_rst_exp", eng_exp, 32'd2753);
    dec_req = 1'b0;
    run_engine(5, 32'd777);
    check("post_rst_valid", {29'd0, res_valid, res_err, res_dec}, 32'b101);
    check("post_rst_data", res_data, 32'd777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
